// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// An owner keeps the port for up to MAX_BURST accepted words, and keeps it while the FIFO is full.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int width     = 16,
  parameter int MAX_BURST = 4,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*width-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [width-1:0]         fifo_data_in,
  output logic                     fifo_write,
  input  logic                     fifo_full,
  output logic [OW-1:0]            owner,
  output logic                     owner_valid
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_q, beat_d;

  logic               owner_req;
  logic               transfer;
  logic               release_own;
  logic [OW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] req_masked;
  logic [OW:0]        pick_idle;
  logic [OW:0]        pick_rel;

  // Returns {found, index} of the first requester at or after p, wrapping modulo NUM_REQ.
  function automatic logic [OW:0] pick(input logic [OW-1:0] p, input logic [NUM_REQ-1:0] r);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (r[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  assign owner_req   = req[owner_q];
  assign transfer    = (state_q == OWN) && !fifo_full && !rst_ && owner_req;
  assign release_own = (transfer && (beat_q == BW'(MAX_BURST - 1))) || !owner_req;
  assign next_ptr    = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // A producer that dropped req forfeits; after burst exhaustion it stays eligible.
  always_comb begin
    req_masked = req;
    if (!owner_req) req_masked[owner_q] = 1'b0;
  end

  assign pick_idle = pick(rr_ptr_q, req);
  assign pick_rel  = pick(next_ptr, req_masked);

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[OW]) begin
          state_d = OWN;
          owner_d = pick_idle[OW-1:0];
          beat_d  = '0;
        end
      end
      OWN: begin
        if (transfer) beat_d = beat_q + 1'b1;
        if (release_own) begin
          rr_ptr_d = next_ptr;
          beat_d   = '0;
          if (pick_rel[OW]) owner_d = pick_rel[OW-1:0];
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if ((state_q == OWN) && !fifo_full && !rst_) gnt[owner_q] = 1'b1;
    fifo_write   = transfer;
    fifo_data_in = (state_q == OWN) ? req_data[owner_q*width +: width] : '0;
    owner        = owner_q;
    owner_valid  = (state_q == OWN);
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed bench for fifo_write_arbiter with a per-cycle behavioural reference.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic             clk;
  logic             rst_;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt;
  logic [W-1:0]     fifo_data_in;
  logic             fifo_write;
  logic             fifo_full;
  logic [1:0]       owner;
  logic             owner_valid;

  fifo_write_arbiter #(.NUM_REQ(N), .width(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_(rst_), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_data_in(fifo_data_in), .fifo_write(fifo_write), .fifo_full(fifo_full),
    .owner(owner), .owner_valid(owner_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the port, how many words it has written, where the pointer sits.
  bit m_owned = 1'b0;
  int m_owner = 0;
  int m_rr    = 0;
  int m_words = 0;
  int wlog[$];

  function automatic int pick_m(int p, logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int  j;
    bit  xfer;
    if (rst_) begin
      m_owned = 1'b0; m_owner = 0; m_rr = 0; m_words = 0;
    end else if (!m_owned) begin
      j = pick_m(m_rr, req);
      if (j >= 0) begin m_owned = 1'b1; m_owner = j; m_words = 0; end
    end else begin
      xfer = req[m_owner] && !fifo_full;
      if (xfer) begin wlog.push_back(m_owner); m_words++; end
      if ((xfer && m_words == MB) || !req[m_owner]) begin
        m_rr = (m_owner + 1) % N;
        m_words = 0;
        j = pick_m(m_rr, req);
        if (j >= 0) m_owner = j;
        else m_owned = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_data;
    bit           live;
    if (chk_en) begin
      live   = m_owned && !fifo_full && !rst_;
      e_gnt  = live ? (N'(1) << m_owner) : '0;
      e_data = m_owned ? req_data[m_owner*W +: W] : '0;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("fifo_write", 32'(fifo_write), 32'(live && req[m_owner]));
      chk("fifo_data_in", 32'(fifo_data_in), 32'(e_data));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("owner_valid", 32'(owner_valid), 32'(m_owned));
    end
  end

  task automatic apply(input bit r, input logic [N-1:0] q, input bit f);
    @(posedge clk);
    #1;
    rst_ = r; req = q; fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  task automatic reset_then(input logic [N-1:0] q);
    apply(1'b1, q, 1'b0);
    apply(1'b1, q, 1'b0);
    apply(1'b0, q, 1'b0);
    wlog.delete();
  endtask

  int exp_order[10] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0};

  initial begin
    logic [N-1:0] rq;
    bit           rr;
    int           ones;
    rst_ = 1'b1; req = 4'b1111; fifo_full = 1'b0; req_data = '0;

    // Reset with everyone requesting, then first grant after one arbitration cycle.
    apply(1'b1, 4'b1111, 1'b0);
    chk_en = 1'b1;
    @(negedge clk);
    chk("t1_rst_gnt", 32'(gnt), 32'h0);
    chk("t1_rst_write", 32'(fifo_write), 32'h0);
    apply(1'b0, 4'b1111, 1'b0);
    @(negedge clk);
    chk("t1_idle_valid", 32'(owner_valid), 32'h0);
    apply(1'b0, 4'b1111, 1'b0);
    @(negedge clk);
    chk("t1_first_gnt", 32'(gnt), 32'h1);
    chk("t1_first_owner", 32'(owner), 32'h0);

    // Burst limit and rotation between producers 0 and 2.
    reset_then(4'b0101);
    repeat (11) apply(1'b0, 4'b0101, 1'b0);
    @(negedge clk);
    chk("t2_words", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++)
      chk("t2_order", 32'(wlog[i]), 32'(exp_order[i]));

    // Sole requester keeps writing every cycle.
    reset_then(4'b1000);
    repeat (10) apply(1'b0, 4'b1000, 1'b0);
    @(negedge clk);
    chk("t3_words", 32'(wlog.size()), 32'd9);
    ones = 0;
    foreach (wlog[i]) if (wlog[i] == 3) ones++;
    chk("t3_all_p3", 32'(ones), 32'd9);
    chk("t3_owner", 32'(owner), 32'd3);

    // Back-pressure during cycles 3..5 of producer 1's burst.
    reset_then(4'b0110);
    for (int c = 1; c <= 8; c++) begin
      apply(1'b0, 4'b0110, (c >= 3 && c <= 5));
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk("t4_full_gnt", 32'(gnt), 32'h0);
        chk("t4_full_write", 32'(fifo_write), 32'h0);
      end
    end
    ones = 0;
    foreach (wlog[i]) if (wlog[i] == 1) ones++;
    chk("t4_p1_words", 32'(ones), 32'd4);
    chk("t4_handover", 32'(owner), 32'd2);

    // Early release by producer 2 after two words.
    reset_then(4'b0100);
    apply(1'b0, 4'b0100, 1'b0);
    apply(1'b0, 4'b0100, 1'b0);
    apply(1'b0, 4'b0001, 1'b0);
    apply(1'b0, 4'b0001, 1'b0);
    @(negedge clk);
    chk("t5_owner", 32'(owner), 32'd0);
    chk("t5_model_rr", 32'(m_rr), 32'd3);
    chk("t5_words", 32'(wlog.size()), 32'd2);

    // Reset during the second beat of producer 1.
    reset_then(4'b0010);
    apply(1'b0, 4'b0010, 1'b0);
    apply(1'b1, 4'b0010, 1'b0);
    @(negedge clk);
    chk("t6_rst_write", 32'(fifo_write), 32'h0);
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    apply(1'b0, 4'b0011, 1'b0);
    @(negedge clk);
    chk("t6_idle_valid", 32'(owner_valid), 32'h0);
    apply(1'b0, 4'b0011, 1'b0);
    @(negedge clk);
    chk("t6_owner", 32'(owner), 32'd0);
    chk("t6_gnt", 32'(gnt), 32'h1);

    // Random traffic, checked every cycle by the compare process.
    rq = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
      rr = ($urandom_range(0, 199) == 0);
      apply(rr, rq, ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
